// File: rtl/nonce_dispatcher.sv
// Nonce issue front-end for the odo_keccak hasher: streams {header, nonce}
// blocks, tracks in-flight nonces and reports the first winning one.
module nonce_dispatcher #(
    parameter int          MAX_INFLIGHT = 16,
    parameter logic [31:0] NONCE_START  = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [607:0] header,
    input  logic [255:0] target,
    input  logic         start,
    input  logic         stop,
    output logic [639:0] blk_out,
    output logic         blk_write,
    output logic [255:0] target_out,
    input  logic         hash_hit,
    input  logic         hash_write,
    output logic [31:0]  nonce,
    output logic         found,
    input  logic         found_ack,
    output logic         exhausted,
    output logic         busy,
    output logic         err
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam logic [AW:0] FULL = (AW+1)'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FOUND
    } state_t;

    state_t         state;
    logic [607:0]   header_q;
    logic [255:0]   target_q;
    logic [31:0]    cnt;
    logic [31:0]    blk_nonce;
    logic [31:0]    head;
    logic [31:0]    mem [MAX_INFLIGHT];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    occ;
    logic [AW:0]    occ_pop;
    logic [AW:0]    occ_next;
    logic           wrap_q;
    logic           ack_q;
    logic           pop;
    logic           spurious;
    logic           hit;
    logic           room;
    logic           issue;
    logic [31:0]    issue_nonce;

    // The issue decision is taken at the edge, so blk_write is a register
    // that is high during the cycle the hasher samples the block.
    always_comb begin
        pop         = hash_write && (occ != '0);
        spurious    = hash_write && (occ == '0);
        hit         = pop && hash_hit && (state == S_RUN);
        occ_pop     = occ - {{AW{1'b0}}, pop};
        room        = (occ_pop != FULL);
        issue_nonce = (state == S_IDLE) ? NONCE_START : cnt;
        issue       = ((state == S_IDLE) && start) ||
                      ((state == S_RUN) && !hit && !stop && room);
        occ_next    = occ_pop + {{AW{1'b0}}, issue};
    end

    assign head       = mem[rd_ptr];
    assign blk_out    = {header_q, blk_nonce};
    assign target_out = target_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (issue) begin
            mem[wr_ptr] <= issue_nonce;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            header_q  <= '0;
            target_q  <= '0;
            cnt       <= NONCE_START;
            blk_nonce <= '0;
            blk_write <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            wrap_q    <= 1'b0;
            ack_q     <= 1'b0;
            nonce     <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            err       <= 1'b0;
        end else begin
            blk_write <= issue;
            exhausted <= 1'b0;
            occ       <= occ_next;
            if (issue) begin
                blk_nonce <= issue_nonce;
                cnt       <= issue_nonce + 32'd1;
                wr_ptr    <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (spurious) begin
                err <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        header_q <= header;
                        target_q <= target;
                        err      <= 1'b0;
                        ack_q    <= 1'b0;
                        found    <= 1'b0;
                        // A run starting at the last nonce wraps immediately.
                        wrap_q   <= (NONCE_START == 32'hFFFF_FFFF);
                        state    <= (NONCE_START == 32'hFFFF_FFFF) ?
                                    S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        nonce <= head;
                        found <= 1'b1;
                        ack_q <= 1'b0;
                        state <= S_FOUND;
                    end else if (stop) begin
                        wrap_q <= 1'b0;
                        state  <= S_DRAIN;
                    end else if (issue && (cnt == 32'hFFFF_FFFF)) begin
                        wrap_q <= 1'b1;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (occ_next == '0) begin
                        exhausted <= wrap_q;
                        wrap_q    <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_FOUND: begin
                    if ((found_ack || ack_q) && (occ_next == '0)) begin
                        found <= 1'b0;
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end else if (found_ack) begin
                        ack_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
